// File: rtl/arm_mem_pkg.sv
// ---------------------------------------------------------------------------
// arm_mem_pkg
// Shared types and default sizing for the unified-memory port arbiter.
//   state_t : arbiter FSM states (IDLE, ACCESS, RESP)
//   grant_t : current owner of the memory port (NONE, INSTR, DATA)
//   ARB_ADDR_W / ARB_DATA_W / ARB_TIMEOUT : default parameter values
// ---------------------------------------------------------------------------
package arm_mem_pkg;

    localparam int ARB_ADDR_W  = 32;
    localparam int ARB_DATA_W  = 32;
    localparam int ARB_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        INSTR = 2'd1,
        DATA  = 2'd2
    } grant_t;

endpackage

// File: rtl/mem_watchdog.sv
// ---------------------------------------------------------------------------
// mem_watchdog
// Per-access cycle counter. Counts while 'run' is high, returns to zero on
// 'clear' (clear has priority), and flags the last permitted wait cycle.
// Ports:
//   clk     : clock
//   reset   : asynchronous, active-low reset
//   run     : count this cycle (access in flight)
//   clear   : return the count to zero
//   expired : count == TIMEOUT-1
// ---------------------------------------------------------------------------
module mem_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop sees
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported unified memory between the fetch stage (i_*) and
// the memory stage (d_*). One access at a time: IDLE picks a winner and
// registers its command onto m_*, ACCESS waits for m_ready (or the watchdog),
// RESP pulses the winner's ack for one cycle.
// Optional build macro ARB_ROUND_ROBIN_EN: alternate winners when both
// requesters are pending; otherwise data always beats fetch (older instr).
// Ports:
//   clk, reset                 : clock, asynchronous active-low reset
//   i_req/i_addr -> i_ack/i_rdata : fetch read channel
//   d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata : data channel
//   err                        : pulses with the ack of a timed-out access
//   m_req/m_we/m_addr/m_wdata, m_rdata/m_ready : memory side
//   stall_f / stall_m          : to hazard unit, requester still waiting
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import arm_mem_pkg::*;
#(
    parameter int ADDR_W  = ARB_ADDR_W,
    parameter int DATA_W  = ARB_DATA_W,
    parameter int TIMEOUT = ARB_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready,
    output logic              stall_f,
    output logic              stall_m
);

    state_t state, state_n;
    grant_t grant, win;
    logic   err_q;
    logic   expired;

`ifdef ARB_ROUND_ROBIN_EN
    grant_t last_grant;
`endif

    mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .run     (state == ACCESS),
        .clear   (state == RESP),
        .expired (expired)
    );

    // Winner selection; only meaningful while IDLE.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        win = NONE;
`ifdef ARB_ROUND_ROBIN_EN
        if (d_req && i_req) begin
            win = (last_grant == DATA) ? INSTR : DATA;
        end else if (d_req) begin
            win = DATA;
        end else if (i_req) begin
            win = INSTR;
        end
`else
        if (d_req) begin
            win = DATA;
        end else if (i_req) begin
            win = INSTR;
        end
`endif
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (win != NONE)          state_n = ACCESS;
            ACCESS:  if (m_ready || expired)   state_n = RESP;
            RESP:                              state_n = IDLE;
            default:                           state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Command / response datapath.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant   <= NONE;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
            err_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= DATA;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (win != NONE) begin
                        grant <= win;
                        m_req <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant <= win;
`endif
                        if (win == DATA) begin
                            m_we    <= d_we;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                        end else begin
                            m_we    <= 1'b0;
                            m_addr  <= i_addr;
                        end
                    end
                end
                ACCESS: begin
                    // m_ready beats a simultaneous timeout; a timed-out read
                    // returns zero rather than whatever is on m_rdata.
                    if (m_ready || expired) begin
                        m_req <= 1'b0;
                        m_we  <= 1'b0;
                        err_q <= ~m_ready;
                        if (!m_we) begin
                            if (grant == DATA) begin
                                d_rdata <= m_ready ? m_rdata : '0;
                            end else if (grant == INSTR) begin
                                i_rdata <= m_ready ? m_rdata : '0;
                            end
                        end
                    end
                end
                RESP: begin
                    grant <= NONE;
                    err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign i_ack = (state == RESP) && (grant == INSTR);
    assign d_ack = (state == RESP) && (grant == DATA);
    assign err   = (state == RESP) && err_q;

    // Gated by reset so the pipeline is released the moment reset asserts,
    // even though the requesters are still holding their req lines.
    assign stall_f = reset & i_req & ~i_ack;
    assign stall_m = reset & d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import arm_mem_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          err;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata = '0;
    logic          m_ready = 1'b0;
    logic          stall_f;
    logic          stall_m;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready),
        .stall_f(stall_f), .stall_m(stall_m)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t iq[$];
    exp_t dq[$];

    // Memory contents the responder returns.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h100: return 32'hE3A0_0005;
            32'h104: return 32'hE281_1001;
            32'h200: return 32'hCAFE_F00D;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Memory responder: m_ready after ready_delay waiting cycles, never if hang.
    logic hang = 1'b0;
    int   ready_delay = 1;
    int   acc_cyc = 0;
    always @(negedge clk) begin
        if (m_req && reset) begin
            if (!hang && acc_cyc == ready_delay) begin
                m_ready = 1'b1;
                m_rdata = mem_rd(m_addr);
            end else begin
                m_ready = 1'b0;
                m_rdata = 32'hDEAD_BEEF;
            end
            acc_cyc++;
        end else begin
            m_ready = 1'b0;
            m_rdata = 32'hDEAD_BEEF;
            acc_cyc = 0;
        end
    end

    // Monitor / scoreboard.
    int          cyc = 0;
    int          i_ack_cyc = 0;
    int          d_ack_cyc = 0;
    int          mreq_run = 0;
    int          last_mreq_run = 0;
    int          stallf_run = 0;
    int          last_stallf_run = 0;
    logic        chk_m = 1'b0;
    logic        exp_m_we = 1'b0;
    logic [31:0] exp_m_addr = '0;
    logic [31:0] exp_m_wdata = '0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!reset) begin
            mreq_run   = 0;
            stallf_run = 0;
        end else begin
            if (i_ack && d_ack) check("dual_ack", 32'd1, 32'd0);
            if (i_ack) begin
                i_ack_cyc = cyc;
                if (iq.size() == 0) check("unexpected_i_ack", 32'd1, 32'd0);
                else begin
                    e = iq.pop_front();
                    check("i_rdata", i_rdata, e.rdata);
                    check("i_err", {31'd0, err}, {31'd0, e.err});
                end
            end
            if (d_ack) begin
                d_ack_cyc = cyc;
                if (dq.size() == 0) check("unexpected_d_ack", 32'd1, 32'd0);
                else begin
                    e = dq.pop_front();
                    check("d_rdata", d_rdata, e.rdata);
                    check("d_err", {31'd0, err}, {31'd0, e.err});
                end
            end
            if (m_req && chk_m) begin
                check("m_addr", m_addr, exp_m_addr);
                check("m_we", {31'd0, m_we}, {31'd0, exp_m_we});
                check("m_wdata", m_wdata, exp_m_wdata);
            end
            if (m_req) mreq_run++;
            else if (mreq_run > 0) begin
                last_mreq_run = mreq_run;
                mreq_run = 0;
            end
            if (stall_f) stallf_run++;
            else if (stallf_run > 0) begin
                last_stallf_run = stallf_run;
                stallf_run = 0;
            end
        end
    end

    task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        int   n;
        e.rdata = exp_rd;
        e.err   = exp_err;
        iq.push_back(e);
        @(posedge clk); #1;
        i_req  = 1'b1;
        i_addr = addr;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!i_ack && n < 40);
        if (!i_ack) check("i_ack_wait", 32'd0, 32'd1);
        @(posedge clk); #1;
        i_req = 1'b0;
    endtask

    task automatic data_acc(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        int   n;
        e.rdata = exp_rd;
        e.err   = exp_err;
        dq.push_back(e);
        @(posedge clk); #1;
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = addr;
        d_wdata = wdata;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!d_ack && n < 40);
        if (!d_ack) check("d_ack_wait", 32'd0, 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0;
        d_we  = 1'b0;
    endtask

    logic exp_data_first;

    initial begin
        // Reset state.
        #1;
        check("rst_m_req", {31'd0, m_req}, 32'd0);
        check("rst_m_we", {31'd0, m_we}, 32'd0);
        check("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        check("rst_m_wdata", m_wdata, 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Single fetch, m_ready one cycle after m_req.
        ready_delay = 1;
        fetch(32'h100, 32'hE3A0_0005, 1'b0);
        check("stall_f_cycles", last_stallf_run, 32'd3);

        // Data read alone.
        data_acc(1'b0, 32'h200, 32'h0, 32'hCAFE_F00D, 1'b0);

        // Data write: command stable on m_* while waiting, d_rdata untouched.
        ready_delay = 2;
        exp_m_we    = 1'b1;
        exp_m_addr  = 32'h300;
        exp_m_wdata = 32'h1234_5678;
        chk_m       = 1'b1;
        data_acc(1'b1, 32'h300, 32'h1234_5678, 32'hCAFE_F00D, 1'b0);
        chk_m       = 1'b0;
        check("write_m_req_cycles", last_mreq_run, 32'd3);

        // Simultaneous requests; last winner was DATA.
        ready_delay = 0;
        fork
            fetch(32'h104, 32'hE281_1001, 1'b0);
            data_acc(1'b0, 32'h100, 32'h0, 32'hE3A0_0005, 1'b0);
        join
`ifdef ARB_ROUND_ROBIN_EN
        exp_data_first = 1'b0;
`else
        exp_data_first = 1'b1;
`endif
        check("order_data_first", {31'd0, d_ack_cyc < i_ack_cyc}, {31'd0, exp_data_first});

        // Timeout: memory never answers.
        hang = 1'b1;
        data_acc(1'b0, 32'h200, 32'h0, 32'h0, 1'b0 | 1'b1);
        check("timeout_m_req_cycles", last_mreq_run, TO);
        hang = 1'b0;

        // Reset mid-access.
        hang = 1'b1;
        @(posedge clk); #1;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h200;
        repeat (3) @(negedge clk);
        check("pre_rst_m_req", {31'd0, m_req}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_m_req", {31'd0, m_req}, 32'd0);
        check("async_d_ack", {31'd0, d_ack}, 32'd0);
        check("async_stall_m", {31'd0, stall_m}, 32'd0);
        d_req = 1'b0;
        hang  = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_m_req", {31'd0, m_req}, 32'd0);
        fetch(32'h100, 32'hE3A0_0005, 1'b0);

        repeat (3) @(negedge clk);
        check("iq_drained", iq.size(), 32'd0);
        check("dq_drained", dq.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (instruction requester) and the memory stage (data requester) of the pipelined ARM core.
- Serialises accesses through a request/ready handshake and registers the read data.
- Raises stall_f / stall_m to the hazard unit while a requester waits.
- Includes a per-access watchdog so a hung memory cannot deadlock the pipeline.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 64, max cycles an access may wait for m_ready before it is aborted (min 2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- i_req  input  1  fetch read request; held until i_ack.
- i_addr  input  ADDR_W  fetch address.
- i_ack  output  1  one-cycle completion pulse for fetch.
- i_rdata  output  DATA_W  fetched instruction; valid with i_ack, held until the next fetch completion.
- d_req  input  1  data request; held until d_ack.
- d_we  input  1  1 = write, 0 = read.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  write data.
- d_ack  output  1  one-cycle completion pulse for data.
- d_rdata  output  DATA_W  load data; valid with d_ack on reads.
- err  output  1  pulses with i_ack/d_ack when the access timed out.
- m_req  output  1  memory access strobe.
- m_we  output  1  memory write enable.
- m_addr  output  ADDR_W  registered access address.
- m_wdata  output  DATA_W  registered write data.
- m_rdata  input  DATA_W  memory read data; valid when m_ready=1.
- m_ready  input  1  memory completes the current access this cycle.
- stall_f  output  1  i_req & ~i_ack (combinational).
- stall_m  output  1  d_req & ~d_ack (combinational).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - m_req, m_we, i_ack, d_ack, err = 0.
  - m_addr, m_wdata, i_rdata, d_rdata = 0.
  - Watchdog counter = 0; grant = NONE.
- Reset mid-access: the access is abandoned, no ack is issued, and the requester re-issues after reset.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req=1, pick a winner.
  - Latch the winner's addr/wdata/we into m_* and the grant register.
  - Set m_req=1 next cycle and go to ACCESS.
  - With no request, m_req=0 and the state stays IDLE.
- Arbitration: fixed priority, data over fetch, because the M-stage instruction is older.
- ACCESS:
  - m_req held high and m_* held stable; the watchdog increments each cycle.
  - If m_ready=1: capture m_rdata into i_rdata or d_rdata per grant (reads only; writes leave d_rdata unchanged). Drop m_req and go to RESP with err=0.
  - Else if watchdog == TIMEOUT-1: drop m_req, load 0 into the granted rdata register (reads), go to RESP with err=1.
  - m_ready and timeout in the same cycle: m_ready wins, err=0.
- RESP:
  - The granted ack=1 for exactly one cycle; err pulses alongside if set.
  - Clear the watchdog and return to IDLE.
  - New requests are not sampled in RESP, so the same requester can drop req.
- Latency: req seen at edge N → m_req high N+1. m_ready sampled at edge N+1+k → ack high in cycle N+2+k. Minimum 3 cycles request-to-ack.
- A requester dropping req before its ack is a protocol violation. The access still completes and the ack is still pulsed.
- The ungranted requester waits. Its stall stays high and it is served in the IDLE following RESP.
- i_ack and d_ack are never high in the same cycle.
- m_ready while not in ACCESS is ignored.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: a last_grant flip-flop (reset value DATA) records the most recent winner. When both requests are pending in IDLE, the requester not in last_grant wins. A single pending request always wins.
- Undefined: fixed data-over-fetch priority; last_grant is not instantiated.

Decomposition:
- Package arm_mem_pkg: state enum (IDLE, ACCESS, RESP), grant enum (NONE, INSTR, DATA), default width/TIMEOUT constants.
- One sub-module, mem_watchdog:
  - Counter of width $clog2(TIMEOUT).
  - Inputs: clk, reset, run, clear.
  - Output: expired = (count == TIMEOUT-1).
- Everything else stays in the top module.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100, m_ready one cycle after m_req, m_rdata=0xE3A00005 → i_ack 3 cycles after request, i_rdata=0xE3A00005, err=0, stall_f high for 3 cycles.
- Simultaneous: i_req=1 and d_req=1 (read 0x200) in the same cycle → data served first, d_ack then i_ack, never the same cycle. With ARB_ROUND_ROBIN_EN and last_grant=DATA, fetch is served first.
- Data write: d_we=1, d_addr=0x300, d_wdata=0x12345678 → m_we=1, m_addr=0x300, m_wdata=0x12345678 held until m_ready; d_ack pulses; d_rdata unchanged.
- Timeout: TIMEOUT=8, m_ready held 0 → m_req high exactly 8 cycles, then d_ack=1 and err=1 in the same cycle, d_rdata=0.
- Reset mid-access: assert reset=0 during ACCESS → m_req, acks, and stalls drop immediately (no clock edge needed). After release, state is IDLE and a fresh request completes normally.
